id_ex_stage: RTL and testbench

- Pipeline register between the DECODE stage (register file, sign extend, control) and the EXECUTE stage (ALU, ALU control, branch adder).
- Captures decoded operands and control each cycle.
- Contains the load-use hazard detector: a one-cycle stall request to the fetch stage and the IF/ID latch, plus a bubble insertion into EXECUTE.
- Supports a flush input from branch resolution and a saturating count of hazard bubbles for performance debug.

---
 rtl/id_ex_stage.sv | 125 ++++++++++++
 tb/tb_id_ex_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush handling and a
// saturating counter of hazard bubbles inserted into EXECUTE.
module id_ex_stage #(
   parameter int DW    = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             valid_in,
   input  logic [1:0]       ctl_wb_in,
   input  logic [2:0]       ctl_m_in,
   input  logic [3:0]       ctl_ex_in,
   input  logic [DW-1:0]    npc_in,
   input  logic [DW-1:0]    rdata1_in,
   input  logic [DW-1:0]    rdata2_in,
   input  logic [DW-1:0]    sext_in,
   input  logic [4:0]       rs_in,
   input  logic [4:0]       rt_in,
   input  logic [4:0]       rd_in,
   output logic [1:0]       ctl_wb,
   output logic [2:0]       ctl_m,
   output logic [3:0]       ctl_ex,
   output logic [DW-1:0]    npc,
   output logic [DW-1:0]    rdata1,
   output logic [DW-1:0]    rdata2,
   output logic [DW-1:0]    sext,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic             valid_out,
   output logic             stall,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             valid_q,  valid_d;
   logic [1:0]       wb_q,     wb_d;
   logic [2:0]       m_q,      m_d;
   logic [3:0]       ex_q,     ex_d;
   logic [DW-1:0]    npc_q,    npc_d;
   logic [DW-1:0]    rd1_q,    rd1_d;
   logic [DW-1:0]    rd2_q,    rd2_d;
   logic [DW-1:0]    sext_q,   sext_d;
   logic [4:0]       rt_q,     rt_d;
   logic [4:0]       rd_q,     rd_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic             load_use;

   // A load in EXECUTE whose destination is read by the instruction in decode.
   assign load_use = valid_q & m_q[1] & (rt_q != 5'd0) &
                     ((rt_q == rs_in) | (rt_q == rt_in));
   assign stall    = load_use & ~flush;

   always_comb begin
      valid_d = valid_in;
      wb_d    = ctl_wb_in;
      m_d     = ctl_m_in;
      ex_d    = ctl_ex_in;
      npc_d   = npc_in;
      rd1_d   = rdata1_in;
      rd2_d   = rdata2_in;
      sext_d  = sext_in;
      rt_d    = rt_in;
      rd_d    = rd_in;
      cnt_d   = cnt_q;
      if (flush || load_use) begin
         valid_d = 1'b0;
         wb_d    = '0;
         m_d     = '0;
         ex_d    = '0;
         npc_d   = '0;
         rd1_d   = '0;
         rd2_d   = '0;
         sext_d  = '0;
         rt_d    = '0;
         rd_d    = '0;
      end
      // Only hazard bubbles are counted; flush bubbles are not.
      if (load_use && !flush && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         wb_q    <= '0;
         m_q     <= '0;
         ex_q    <= '0;
         npc_q   <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         sext_q  <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         wb_q    <= wb_d;
         m_q     <= m_d;
         ex_q    <= ex_d;
         npc_q   <= npc_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         sext_q  <= sext_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign valid_out  = valid_q;
   assign ctl_wb     = wb_q;
   assign ctl_m      = m_q;
   assign ctl_ex     = ex_q;
   assign npc        = npc_q;
   assign rdata1     = rd1_q;
   assign rdata2     = rd2_q;
   assign sext       = sext_q;
   assign rt         = rt_q;
   assign rd         = rd_q;
   assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic, checked against
// a slot-level model of the EXECUTE latch and the bubble counter.
module tb_id_ex_stage;

   localparam int DW      = 32;
   localparam int CNT_W   = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic          v;
      logic [1:0]    wb;
      logic [2:0]    m;
      logic [3:0]    ex;
      logic [DW-1:0] npc;
      logic [DW-1:0] r1;
      logic [DW-1:0] r2;
      logic [DW-1:0] sx;
      logic [4:0]    rt;
      logic [4:0]    rd;
   } slot_t;

   logic             clk = 1'b0;
   logic             rst, flush, valid_in;
   logic [1:0]       ctl_wb_in;
   logic [2:0]       ctl_m_in;
   logic [3:0]       ctl_ex_in;
   logic [DW-1:0]    npc_in, rdata1_in, rdata2_in, sext_in;
   logic [4:0]       rs_in, rt_in, rd_in;
   logic [1:0]       ctl_wb;
   logic [2:0]       ctl_m;
   logic [3:0]       ctl_ex;
   logic [DW-1:0]    npc, rdata1, rdata2, sext;
   logic [4:0]       rt, rd;
   logic             valid_out, stall;
   logic [CNT_W-1:0] bubble_cnt;

   slot_t mdl;
   int    exp_cnt;
   int    n_checks = 0;
   int    n_pass   = 0;

   id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in),
      .ctl_wb_in(ctl_wb_in), .ctl_m_in(ctl_m_in), .ctl_ex_in(ctl_ex_in),
      .npc_in(npc_in), .rdata1_in(rdata1_in), .rdata2_in(rdata2_in),
      .sext_in(sext_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
      .ctl_wb(ctl_wb), .ctl_m(ctl_m), .ctl_ex(ctl_ex), .npc(npc),
      .rdata1(rdata1), .rdata2(rdata2), .sext(sext), .rt(rt), .rd(rd),
      .valid_out(valid_out), .stall(stall), .bubble_cnt(bubble_cnt)
   );

   always #5 clk = ~clk;

   // Does the instruction now in EXECUTE (model) load a register decode reads?
   function automatic logic model_hazard();
      return mdl.v && mdl.m == 3'b010 || (mdl.v && mdl.m[1]) ?
             (mdl.rt != 5'd0 && (mdl.rt == rs_in || mdl.rt == rt_in)) : 1'b0;
   endfunction

   task automatic drive_idle();
      rst = 1'b0; flush = 1'b0; valid_in = 1'b0;
      ctl_wb_in = '0; ctl_m_in = '0; ctl_ex_in = '0;
      npc_in = '0; rdata1_in = '0; rdata2_in = '0; sext_in = '0;
      rs_in = '0; rt_in = '0; rd_in = '0;
   endtask

   task automatic drive_random(input logic small_regs);
      valid_in  = 1'($urandom_range(0, 1));
      ctl_wb_in = 2'($urandom_range(0, 3));
      ctl_m_in  = 3'($urandom_range(0, 7));
      ctl_ex_in = 4'($urandom_range(0, 15));
      npc_in    = $urandom; rdata1_in = $urandom;
      rdata2_in = $urandom; sext_in   = $urandom;
      if (small_regs) begin
         rs_in = 5'($urandom_range(0, 3));
         rt_in = 5'($urandom_range(0, 3));
         rd_in = 5'($urandom_range(0, 3));
      end else begin
         rs_in = 5'($urandom_range(0, 31));
         rt_in = 5'($urandom_range(0, 31));
         rd_in = 5'($urandom_range(0, 31));
      end
   endtask

   // Decode slot with chosen valid/mem control and register fields, random data.
   task automatic drive_dec(input logic v, input logic [2:0] m,
                            input logic [4:0] rs_v, input logic [4:0] rt_v,
                            input logic [4:0] rd_v);
      drive_random(1'b0);
      valid_in = v; ctl_m_in = m;
      rs_in = rs_v; rt_in = rt_v; rd_in = rd_v;
   endtask

   // Checks stall against the current inputs, advances one clock, checks outputs.
   task automatic step(input string name);
      logic  exp_stall;
      slot_t act;
      logic [CNT_W-1:0] exp_c;
      #1;
      exp_stall = model_hazard() && !flush;
      n_checks++;
      if (stall !== exp_stall)
         $display("FAIL %s stall: got %b want %b", name, stall, exp_stall);
      else n_pass++;
      if (rst) begin
         mdl = '0; exp_cnt = 0;
      end else if (flush) begin
         mdl = '0;
      end else if (model_hazard()) begin
         mdl = '0;
         if (exp_cnt < CNT_MAX) exp_cnt++;
      end else begin
         mdl = {valid_in, ctl_wb_in, ctl_m_in, ctl_ex_in, npc_in, rdata1_in,
                rdata2_in, sext_in, rt_in, rd_in};
      end
      @(posedge clk);
      #1;
      act = {valid_out, ctl_wb, ctl_m, ctl_ex, npc, rdata1, rdata2, sext, rt, rd};
      n_checks++;
      if (act !== mdl)
         $display("FAIL %s slot: got %h want %h", name, act, mdl);
      else n_pass++;
      exp_c = CNT_W'(exp_cnt);
      n_checks++;
      if (bubble_cnt !== exp_c)
         $display("FAIL %s bubble_cnt: got %0d want %0d", name, bubble_cnt, exp_c);
      else n_pass++;
   endtask

   task automatic do_reset();
      drive_random(1'b0);
      rst = 1'b1;
      step("reset");
      drive_idle();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive_random(1'b0);
         rst   = 1'b1;
         flush = 1'($urandom_range(0, 1));
         step("reset_hold");
      end
      drive_random(1'b0);
      rst = 1'b0; flush = 1'b0;
      #1;
      n_checks++;
      if (stall !== 1'b0 || valid_out !== 1'b0 || bubble_cnt !== '0)
         $display("FAIL reset_after: got stall=%b valid=%b cnt=%0d want 0/0/0",
                  stall, valid_out, bubble_cnt);
      else n_pass++;
      step("reset_after");
   endtask

   task automatic test_pass_through();
      do_reset();
      valid_in = 1'b1; ctl_wb_in = 2'b10; ctl_m_in = 3'b000; ctl_ex_in = 4'b1100;
      npc_in = 32'h0000_0004; rdata1_in = 32'h1111_1111;
      rdata2_in = 32'h2222_2222; sext_in = 32'hFFFF_FFF0;
      rs_in = 5'd3; rt_in = 5'd5; rd_in = 5'd7;
      step("pass_through");
      n_checks++;
      if ({valid_out, ctl_wb, ctl_ex, npc, sext, rt, rd} !==
          {1'b1, 2'b10, 4'b1100, 32'h0000_0004, 32'hFFFF_FFF0, 5'd5, 5'd7})
         $display("FAIL pass_fixed: got v=%b wb=%b ex=%b npc=%h sx=%h rt=%0d rd=%0d",
                  valid_out, ctl_wb, ctl_ex, npc, sext, rt, rd);
      else n_pass++;
   endtask

   task automatic test_load_use();
      do_reset();
      drive_dec(1'b1, 3'b010, 5'd1, 5'd8, 5'd0);
      step("lu_load");
      drive_dec(1'b1, 3'b000, 5'd8, 5'd2, 5'd3);
      #1;
      n_checks++;
      if (stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall);
      else n_pass++;
      step("lu_dep");
      n_checks++;
      if (valid_out !== 1'b0 || {ctl_wb, ctl_m, ctl_ex} !== 9'd0 || bubble_cnt !== 2'd1)
         $display("FAIL lu_bubble: got v=%b ctl=%h cnt=%0d want 0/0/1",
                  valid_out, {ctl_wb, ctl_m, ctl_ex}, bubble_cnt);
      else n_pass++;
      step("lu_after");
   endtask

   task automatic test_no_hazard();
      do_reset();
      drive_dec(1'b1, 3'b010, 5'd1, 5'd0, 5'd0);
      step("nh_r0_load");
      drive_dec(1'b1, 3'b000, 5'd0, 5'd0, 5'd4);
      step("nh_r0_use");
      drive_dec(1'b1, 3'b010, 5'd1, 5'd8, 5'd0);
      step("nh_r8_load");
      drive_dec(1'b1, 3'b000, 5'd9, 5'd10, 5'd4);
      step("nh_r8_use");
      drive_dec(1'b0, 3'b010, 5'd1, 5'd6, 5'd0);
      step("nh_invalid_load");
      drive_dec(1'b1, 3'b000, 5'd6, 5'd6, 5'd4);
      step("nh_invalid_use");
   endtask

   task automatic test_flush_vs_hazard();
      do_reset();
      drive_dec(1'b1, 3'b010, 5'd1, 5'd8, 5'd0);
      step("fh_load");
      drive_dec(1'b1, 3'b000, 5'd8, 5'd8, 5'd2);
      flush = 1'b1;
      step("fh_flush");
      flush = 1'b0;
      drive_dec(1'b1, 3'b000, 5'd8, 5'd8, 5'd2);
      step("fh_after");
   endtask

   task automatic test_saturation();
      logic [CNT_W-1:0] sat_exp [5];
      sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive_dec(1'b1, 3'b010, 5'd0, 5'd12, 5'd0);
         step("sat_load");
         drive_dec(1'b1, 3'b001, 5'd4, 5'd12, 5'd0);
         step("sat_dep");
         n_checks++;
         if (bubble_cnt !== sat_exp[i])
            $display("FAIL sat_%0d: got %0d want %0d", i, bubble_cnt, sat_exp[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      drive_dec(1'b1, 3'b010, 5'd1, 5'd9, 5'd0);
      step("rm_load");
      drive_dec(1'b1, 3'b000, 5'd9, 5'd2, 5'd3);
      rst = 1'b1;
      step("rm_reset");
      drive_dec(1'b1, 3'b000, 5'd9, 5'd9, 5'd3);
      step("rm_after");
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         drive_random(1'b1);
         if ($urandom_range(0, 2) == 0) ctl_m_in = 3'b010;
         flush = ($urandom_range(0, 9) == 0);
         rst   = ($urandom_range(0, 49) == 0);
         step("random");
      end
   endtask

   initial begin
      mdl = '0;
      exp_cnt = 0;
      drive_idle();
      test_reset();
      test_pass_through();
      test_load_use();
      test_no_hazard();
      test_flush_vs_hazard();
      test_saturation();
      test_reset_mid_stall();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
